traffic_timebase: RTL and testbench

Upstream timing and request front-end for the intersection controller. Divides the board clock into a one-cycle `sec_tick` strobe, which the light sequencer uses as its count enable so its countdowns run in seconds. Synchronises and debounces raw pedestrian/vehicle inputs and holds each as a sticky request until the sequencer acknowledges it.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/debounce_sync.sv | 68 ++++++
 rtl/traffic_timebase.sv | 84 ++++++++
 tb/tb_traffic_timebase.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: light encodings,
// sequencer states, phase durations and request channel indices.
package traffic_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;

  localparam int unsigned REQ_PED    = 0;
  localparam int unsigned REQ_EW_CAR = 1;

  localparam int unsigned GREEN_SECS  = 10;
  localparam int unsigned YELLOW_SECS = 2;

  typedef enum logic [2:0] {
    LIGHT_GREEN  = 3'b001,
    LIGHT_YELLOW = 3'b010,
    LIGHT_RED    = 3'b100
  } light_e;

  typedef enum logic [2:0] {
    SEQ_NS_GREEN  = 3'd0,
    SEQ_NS_YELLOW = 3'd1,
    SEQ_EW_GREEN  = 3'd2,
    SEQ_EW_YELLOW = 3'd3,
    SEQ_PED_WALK  = 3'd4
  } seq_state_e;

  // Debounce FSM state; the encoding doubles as the debounced level.
  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_sync.sv
// One request channel: two-flop synchroniser followed by a debounce FSM that
// accepts a level change only after DEBOUNCE_MS consecutive mismatching ms ticks.
module debounce_sync
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic ms_tick_i,
  output logic level_o
);

  localparam int unsigned STAB_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_MS - 1);

  logic              meta_q;
  logic              sync_q;
  db_state_e         state_q;
  db_state_e         state_d;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_d;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DB_RELEASED;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  assign mismatch = (sync_q != (state_q == DB_PRESSED));

  // A single matching cycle clears the count, so only an unbroken mismatch can toggle.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    if (!mismatch) begin
      stab_d = '0;
    end else if (ms_tick_i) begin
      if (stab_q == STAB_LAST) begin
        state_d = (state_q == DB_PRESSED) ? DB_RELEASED : DB_PRESSED;
        stab_d  = '0;
      end else begin
        stab_d = stab_q + STAB_W'(1);
      end
    end
  end

  always_comb begin
    level_o = (state_q == DB_PRESSED);
  end

endmodule

// File: rtl/traffic_timebase.sv
// Second/millisecond prescalers plus synchronised, debounced, sticky request
// flags for the light sequencer.
module traffic_timebase
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned NUM_REQ     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] btn_raw,
  input  logic [NUM_REQ-1:0] req_ack,
  output logic               sec_tick,
  output logic               ms_tick,
  output logic [NUM_REQ-1:0] req_level,
  output logic [NUM_REQ-1:0] req_pending
);

  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned MS_DIV = CLK_HZ / 1000;
  localparam int unsigned SEC_W  = $clog2(DIV);
  localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_DIV - 1);

  logic [SEC_W-1:0]   sec_cnt_q;
  logic [SEC_W-1:0]   sec_cnt_d;
  logic [MS_W-1:0]    ms_cnt_q;
  logic [MS_W-1:0]    ms_cnt_d;
  logic [NUM_REQ-1:0] level_prev_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_d;
  logic [NUM_REQ-1:0] rise;

  always_comb begin
    sec_tick  = (sec_cnt_q == SEC_LAST);
    ms_tick   = (ms_cnt_q == MS_LAST);
    sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
    ms_cnt_d  = ms_tick ? '0 : ms_cnt_q + MS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt_q <= '0;
      ms_cnt_q  <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ms_cnt_q  <= ms_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    debounce_sync #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[g]),
      .ms_tick_i(ms_tick),
      .level_o  (req_level[g])
    );
  end

  // Set has priority over ack so a press coinciding with an ack is never lost.
  always_comb begin
    rise      = req_level & ~level_prev_q;
    pending_d = rise | (pending_q & ~req_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= '0;
      pending_q    <= '0;
    end else begin
      level_prev_q <= req_level;
      pending_q    <= pending_d;
    end
  end

  assign req_pending = pending_q;

endmodule

// File: tb/tb_traffic_timebase.sv
// Bench for traffic_timebase: every cycle is compared against a reference
// model, plus a vector table and hand-written corner-case sequences.
module tb_traffic_timebase;

  localparam int CLK_HZ      = 10_000;
  localparam int TICK_HZ     = 1;
  localparam int DEBOUNCE_MS = 3;
  localparam int NUM_REQ     = 2;
  localparam int DIV         = CLK_HZ / TICK_HZ;
  localparam int MS_DIV      = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] req_ack;
  logic       sec_tick;
  logic       ms_tick;
  logic [1:0] req_level;
  logic [1:0] req_pending;

  always #5 clk = ~clk;

  traffic_timebase #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .NUM_REQ    (NUM_REQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .req_ack    (req_ack),
    .sec_tick   (sec_tick),
    .ms_tick    (ms_tick),
    .req_level  (req_level),
    .req_pending(req_pending)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index since reset, raw-input history, and per-channel
  // count of ms ticks seen during the current unbroken disagreement.
  int         m_cyc;
  logic [1:0] m_hist[$];
  logic [1:0] m_level;
  logic [1:0] m_lprev;
  logic [1:0] m_pend;
  int         m_run[2];

  typedef struct {
    logic [1:0] btn;
    logic [1:0] ack;
    int         cycles;
    logic [1:0] exp_level;
    logic [1:0] exp_pend;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_edge();
    logic [1:0] sync;
    logic       ms_now;
    if (rst) begin
      m_cyc = 0;
      m_hist.delete();
      m_hist.push_back(2'b00);
      m_hist.push_back(2'b00);
      m_level  = 2'b00;
      m_lprev  = 2'b00;
      m_pend   = 2'b00;
      m_run[0] = 0;
      m_run[1] = 0;
    end else begin
      sync   = m_hist[0];
      ms_now = ((m_cyc % MS_DIV) == MS_DIV - 1);
      m_pend  = (m_level & ~m_lprev) | (m_pend & ~req_ack);
      m_lprev = m_level;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync[ch] != m_level[ch]) begin
          if (ms_now) begin
            m_run[ch]++;
            if (m_run[ch] == DEBOUNCE_MS) begin
              m_level[ch] = ~m_level[ch];
              m_run[ch]   = 0;
            end
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_hist.push_back(btn_raw);
      void'(m_hist.pop_front());
      m_cyc++;
    end
  endtask

  function automatic int model_expect();
    logic s;
    logic m;
    s = ((m_cyc % DIV) == DIV - 1);
    m = ((m_cyc % MS_DIV) == MS_DIV - 1);
    return int'({s, m, m_level, m_pend});
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", int'({sec_tick, ms_tick, req_level, req_pending}), model_expect());
  endtask

  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_sec;
    int sec_cnt;
    int ms_cnt;
    int first_pend;
    int t0;
    int t1;
    int hold;
    logic found;

    vecs[0] = '{2'b00, 2'b00, 60, 2'b00, 2'b00};
    vecs[1] = '{2'b01, 2'b00, 40, 2'b01, 2'b01};
    vecs[2] = '{2'b01, 2'b01,  1, 2'b01, 2'b00};
    vecs[3] = '{2'b01, 2'b00, 60, 2'b01, 2'b00};
    vecs[4] = '{2'b00, 2'b00, 40, 2'b00, 2'b00};
    vecs[5] = '{2'b10, 2'b00, 40, 2'b10, 2'b10};
    vecs[6] = '{2'b11, 2'b00, 40, 2'b11, 2'b11};
    vecs[7] = '{2'b11, 2'b10,  1, 2'b11, 2'b01};
    vecs[8] = '{2'b00, 2'b01, 40, 2'b00, 2'b00};

    // Reset state
    rst = 1'b1; btn_raw = 2'b00; req_ack = 2'b00;
    step();
    check("reset sec_tick", int'(sec_tick), 0);
    check("reset ms_tick", int'(ms_tick), 0);
    check("reset req_level", int'(req_level), 0);
    check("reset req_pending", int'(req_pending), 0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      btn_raw = vecs[v].btn;
      req_ack = vecs[v].ack;
      for (int c = 0; c < vecs[v].cycles; c++) step();
      check($sformatf("vec%0d level", v), int'(req_level), int'(vecs[v].exp_level));
      check($sformatf("vec%0d pending", v), int'(req_pending), int'(vecs[v].exp_pend));
    end
    req_ack = 2'b00;

    // Fresh reset: timed press on ch0, bouncing ch1, then reset mid-press
    rst = 1'b1;
    step();
    rst = 1'b0;
    while (m_cyc < 5005) begin
      btn_raw[0] = (m_cyc >= 100);
      if (m_cyc >= 200 && m_cyc < 400) btn_raw[1] = (((m_cyc - 200) / 5) % 2 == 0);
      else btn_raw[1] = 1'b0;
      step();
      if (m_cyc == 133) begin
        check("press level by 132", int'(req_level[0]), 1);
        check("press pending", int'(req_pending[0]), 1);
      end
      if (m_cyc == 450) begin
        check("bounce level", int'(req_level[1]), 0);
        check("bounce pending", int'(req_pending[1]), 0);
      end
      if (m_cyc == 5004) check("held single request", int'(req_pending[0]), 1);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset outputs", int'({sec_tick, ms_tick, req_level, req_pending}), 0);
    first_sec = -1; sec_cnt = 0; ms_cnt = 0; first_pend = -1;
    for (int i = 1; i <= 30000; i++) begin
      step();
      if (sec_tick) begin
        sec_cnt++;
        if (first_sec < 0) first_sec = m_cyc;
      end
      if (ms_tick) ms_cnt++;
      if (req_pending[0] && first_pend < 0) first_pend = m_cyc;
    end
    check("first sec_tick cycle", first_sec, 9999);
    check("sec_tick count", sec_cnt, 3);
    check("ms_tick count", ms_cnt, 3000);
    check("re-request after reset", first_pend, 31);

    // Ack clears; ack coinciding with a new rising transition loses to the set
    req_ack = 2'b01;
    step();
    req_ack = 2'b00;
    check("ack clears", int'(req_pending[0]), 0);
    btn_raw = 2'b00;
    repeat (60) step();
    check("release level", int'(req_level), 0);
    btn_raw = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (req_level[0]) found = 1'b1;
    end
    check("re-press seen", int'(found), 1);
    if (found) begin
      req_ack = 2'b01;
      step();
      req_ack = 2'b00;
      check("set beats ack", int'(req_pending[0]), 1);
    end

    // Simultaneous press on both channels, then ack only channel 1
    btn_raw = 2'b00;
    repeat (60) step();
    req_ack = 2'b11;
    step();
    req_ack = 2'b00;
    check("dual cleared", int'(req_pending), 0);
    btn_raw = 2'b11;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (req_pending[0] && t0 < 0) t0 = m_cyc;
      if (req_pending[1] && t1 < 0) t1 = m_cyc;
    end
    check("dual seen", int'(t0 >= 0 && t1 >= 0), 1);
    check("dual same cycle", t1, t0);
    req_ack = 2'b10;
    step();
    req_ack = 2'b00;
    check("ack ch1 only", int'(req_pending), 1);

    // Random stimulus against the model
    for (int s = 0; s < 150; s++) begin
      btn_raw = 2'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 45));
      for (int c = 0; c < hold; c++) begin
        req_ack = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        rst = ($urandom_range(0, 999) == 0);
        step();
        rst = 1'b0;
      end
    end
    req_ack = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
